// File: rtl/dm_resp_pkg.sv
// dm_resp_pkg: shared types and constants for the SH4 data-memory bus responder.
//   - Physical address windows (29-bit) for work SDRAM and the HOLLY register block.
//   - Responder state encoding and decode target encoding.
//   - Lane-select helpers that pick the 32-bit half of a 64-bit beat
//     addressed by dm_req_addr[2].
package dm_resp_pkg;

  localparam logic [28:0] SDRAM_BASE  = 29'h0C00_0000;
  localparam logic [28:0] SDRAM_LIMIT = 29'h0CFF_FFFF;
  localparam logic [28:0] REG_BASE    = 29'h005F_6800;
  localparam logic [28:0] REG_LIMIT   = 29'h005F_9FFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    REG_WAIT = 2'd2,
    RESP     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TGT_RAM  = 2'd0,
    TGT_REG  = 2'd1,
    TGT_NONE = 2'd2
  } target_e;

  // Upper half when hi is set, lower half otherwise.
  function automatic logic [31:0] sel_lane32(input logic [63:0] d, input logic hi);
    return hi ? d[63:32] : d[31:0];
  endfunction

  function automatic logic [3:0] sel_lane4(input logic [7:0] m, input logic hi);
    return hi ? m[7:4] : m[3:0];
  endfunction

endpackage

// File: rtl/dm_addr_decode.sv
// dm_addr_decode: combinational region decode of a 29-bit physical address.
// Ports:
//   addr [28:0] in  - physical address (upper request-address bits already stripped)
//   tgt         out - TGT_RAM for work SDRAM, TGT_REG for HOLLY registers,
//                     TGT_NONE for anything else
module dm_addr_decode
  import dm_resp_pkg::*;
(
  input  logic [28:0] addr,
  output target_e     tgt
);

  // Window compare; the two windows are disjoint so order does not matter.
  always_comb begin
    tgt = TGT_NONE;
    if ((addr >= SDRAM_BASE) && (addr <= SDRAM_LIMIT)) begin
      tgt = TGT_RAM;
    end else if ((addr >= REG_BASE) && (addr <= REG_LIMIT)) begin
      tgt = TGT_REG;
    end else begin
      tgt = TGT_NONE;
    end
  end

endmodule

// File: rtl/dm_bus_responder.sv
// dm_bus_responder: responder end of the SH4 data-memory request bus.
// Accepts one request at a time in IDLE, routes it to work SDRAM (ram_*),
// the 32-bit HOLLY register port (reg_*) or an internal unmapped sink, and
// returns a one-cycle dm_resp_valid carrying 64-bit read data. Every wait
// for ram_ack/reg_ready is bounded by TIMEOUT_CYCLES; expiry forces an
// error response with ERR_RDATA and a bus_error pulse.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   dm_req_*            - request from the core (held until dm_resp_valid)
//   dm_resp_rdata/valid - response to the core
//   ram_*               - work-SDRAM port (ram_req held until ram_ack)
//   reg_*               - register port (reg_rd/reg_wr held until reg_ready)
//   bus_error           - pulses with a timeout response
// Build option DM_ERR_LOG_EN: adds err_addr (address of the first timeout
// or unmapped access since reset) and err_count (saturating count of both).
module dm_bus_responder
  import dm_resp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [63:0] UNMAPPED_RDATA = 64'h0,
  parameter logic [63:0] ERR_RDATA      = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dm_req_addr,
  input  logic [63:0] dm_req_wdata,
  input  logic [7:0]  dm_req_wmask,
  input  logic        dm_req_wen,
  input  logic        dm_req_valid,
  output logic [63:0] dm_resp_rdata,
  output logic        dm_resp_valid,
  output logic [23:0] ram_addr,
  output logic [63:0] ram_wdata,
  output logic [7:0]  ram_wmask,
  output logic        ram_we,
  output logic        ram_req,
  input  logic [63:0] ram_rdata,
  input  logic        ram_ack,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  output logic        reg_rd,
  output logic        reg_wr,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ready,
  output logic        bus_error
`ifdef DM_ERR_LOG_EN
  ,
  output logic [31:0] err_addr,
  output logic [7:0]  err_count
`endif
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  target_e tgt_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             resp_valid_q, resp_valid_d;
  logic             bus_error_q, bus_error_d;
  logic [23:0]      ram_addr_q, ram_addr_d;
  logic [63:0]      ram_wdata_q, ram_wdata_d;
  logic [7:0]       ram_wmask_q, ram_wmask_d;
  logic             ram_we_q, ram_we_d;
  logic             ram_req_q, ram_req_d;
  logic [15:0]      reg_addr_q, reg_addr_d;
  logic [31:0]      reg_wdata_q, reg_wdata_d;
  logic [3:0]       reg_be_q, reg_be_d;
  logic             reg_rd_q, reg_rd_d;
  logic             reg_wr_q, reg_wr_d;
  logic             log_err_s;
  logic [31:0]      err_addr_q, err_addr_d;
  logic [7:0]       err_count_q, err_count_d;

  // The upper request-address bits only matter to the error log.
  logic unused_s;
  assign unused_s = ^{dm_req_addr[31:29], log_err_s, err_addr_q, err_count_q};

  dm_addr_decode u_decode (
    .addr (dm_req_addr[28:0]),
    .tgt  (tgt_s)
  );

  // Next-state and next-output logic for the request/response sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    bus_error_d  = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_wmask_d  = ram_wmask_q;
    ram_we_d     = ram_we_q;
    ram_req_d    = ram_req_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_be_d     = reg_be_q;
    reg_rd_d     = reg_rd_q;
    reg_wr_d     = reg_wr_q;
    log_err_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (dm_req_valid) begin
          case (tgt_s)
            TGT_RAM: begin
              state_d     = RAM_WAIT;
              cnt_d       = '0;
              ram_addr_d  = dm_req_addr[23:0];
              ram_wdata_d = dm_req_wdata;
              ram_wmask_d = dm_req_wmask;
              ram_we_d    = dm_req_wen;
              ram_req_d   = 1'b1;
            end
            TGT_REG: begin
              state_d     = REG_WAIT;
              cnt_d       = '0;
              reg_addr_d  = dm_req_addr[15:0];
              reg_wdata_d = sel_lane32(dm_req_wdata, dm_req_addr[2]);
              reg_be_d    = sel_lane4(dm_req_wmask, dm_req_addr[2]);
              reg_rd_d    = ~dm_req_wen;
              reg_wr_d    = dm_req_wen;
            end
            default: begin
              // Unmapped: writes vanish, reads return the fill pattern, no error.
              state_d      = RESP;
              rdata_d      = UNMAPPED_RDATA;
              resp_valid_d = 1'b1;
              log_err_s    = 1'b1;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end

      RAM_WAIT: begin
        // ram_ack is checked first so an ack on the expiry cycle still wins.
        if (ram_ack) begin
          state_d      = RESP;
          rdata_d      = ram_rdata;
          resp_valid_d = 1'b1;
          ram_req_d    = 1'b0;
          ram_we_d     = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = RESP;
          rdata_d      = ERR_RDATA;
          resp_valid_d = 1'b1;
          bus_error_d  = 1'b1;
          ram_req_d    = 1'b0;
          ram_we_d     = 1'b0;
          log_err_s    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      REG_WAIT: begin
        if (reg_ready) begin
          state_d      = RESP;
          rdata_d      = {reg_rdata, reg_rdata};
          resp_valid_d = 1'b1;
          reg_rd_d     = 1'b0;
          reg_wr_d     = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = RESP;
          rdata_d      = ERR_RDATA;
          resp_valid_d = 1'b1;
          bus_error_d  = 1'b1;
          reg_rd_d     = 1'b0;
          reg_wr_d     = 1'b0;
          log_err_s    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        // Response pulse is visible in this state; the held request is not
        // re-sampled until IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Error log update: first offending address is latched, count saturates.
  always_comb begin
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
`ifdef DM_ERR_LOG_EN
    if (log_err_s) begin
      if (err_count_q == 8'd0) begin
        err_addr_d = dm_req_addr;
      end else begin
        err_addr_d = err_addr_q;
      end
      if (err_count_q != 8'd255) begin
        err_count_d = err_count_q + 8'd1;
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      err_count_d = err_count_q;
    end
`else
    err_addr_d  = 32'd0;
    err_count_d = 8'd0;
`endif
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rdata_q      <= 64'd0;
      resp_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
      ram_addr_q   <= 24'd0;
      ram_wdata_q  <= 64'd0;
      ram_wmask_q  <= 8'd0;
      ram_we_q     <= 1'b0;
      ram_req_q    <= 1'b0;
      reg_addr_q   <= 16'd0;
      reg_wdata_q  <= 32'd0;
      reg_be_q     <= 4'd0;
      reg_rd_q     <= 1'b0;
      reg_wr_q     <= 1'b0;
      err_addr_q   <= 32'd0;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      bus_error_q  <= bus_error_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_wmask_q  <= ram_wmask_d;
      ram_we_q     <= ram_we_d;
      ram_req_q    <= ram_req_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_be_q     <= reg_be_d;
      reg_rd_q     <= reg_rd_d;
      reg_wr_q     <= reg_wr_d;
      err_addr_q   <= err_addr_d;
      err_count_q  <= err_count_d;
    end
  end

  assign dm_resp_rdata = rdata_q;
  assign dm_resp_valid = resp_valid_q;
  assign bus_error     = bus_error_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram_wmask     = ram_wmask_q;
  assign ram_we        = ram_we_q;
  assign ram_req       = ram_req_q;
  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;
  assign reg_be        = reg_be_q;
  assign reg_rd        = reg_rd_q;
  assign reg_wr        = reg_wr_q;
`ifdef DM_ERR_LOG_EN
  assign err_addr      = err_addr_q;
  assign err_count     = err_count_q;
`endif

endmodule
